// File: rtl/jpeg_byte_stuffer.sv
// JPEG entropy-data byte stuffer: pops 32-bit FIFO words, emits them MSB-first, inserts 0x00 after 0xFF.
// Optional macro JPEG_EOI_APPEND_EN appends an FF/EOI_CODE end-of-image marker on eoi_req.
module jpeg_byte_stuffer #(
  parameter int unsigned CNT_W    = 32,
  parameter logic [7:0]  EOI_CODE = 8'hD9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [31:0]      read_data,
  input  logic             rdata_valid,
  output logic             read_req,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  input  logic             byte_ready,
  input  logic             eoi_req,
  output logic             eoi_done,
  output logic             busy,
  output logic [CNT_W-1:0] byte_count,
  output logic [CNT_W-1:0] stuff_count
);

`ifdef JPEG_EOI_APPEND_EN
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SEND, S_STUFF, S_EOI_FF, S_EOI_CODE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SEND, S_STUFF} state_t;
`endif

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t      state, state_next;
  logic [31:0] word_q;
  logic [31:0] word_shifted;
  logic [7:0]  cur_byte;
  logic [1:0]  idx, idx_next;
  logic        fire;

  // Current byte selected by shifting the held word so the active byte sits in the top lane.
  assign word_shifted = word_q << {idx, 3'b000};
  assign cur_byte     = word_shifted[31:24];
  assign fire         = byte_valid & byte_ready;
  assign busy         = (state != S_IDLE);

`ifdef JPEG_EOI_APPEND_EN
  logic eoi_pending;
`endif

  always_comb begin
    state_next = state;
    idx_next   = idx;
    read_req   = 1'b0;
    byte_valid = 1'b0;
    byte_out   = '0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          read_req   = 1'b1;
          state_next = S_WAIT;
        end
`ifdef JPEG_EOI_APPEND_EN
        else if (eoi_pending) begin
          state_next = S_EOI_FF;
        end
`endif
      end
      S_WAIT: begin
        if (rdata_valid) begin
          idx_next   = '0;
          state_next = S_SEND;
        end
      end
      S_SEND: begin
        byte_valid = 1'b1;
        byte_out   = cur_byte;
        if (byte_ready) begin
          if (cur_byte == 8'hFF) begin
            state_next = S_STUFF;
          end else if (idx == 2'd3) begin
            state_next = S_IDLE;
          end else begin
            idx_next = idx + 2'd1;
          end
        end
      end
      S_STUFF: begin
        byte_valid = 1'b1;
        byte_out   = 8'h00;
        if (byte_ready) begin
          if (idx == 2'd3) begin
            state_next = S_IDLE;
          end else begin
            idx_next   = idx + 2'd1;
            state_next = S_SEND;
          end
        end
      end
`ifdef JPEG_EOI_APPEND_EN
      S_EOI_FF: begin
        byte_valid = 1'b1;
        byte_out   = 8'hFF;
        if (byte_ready) state_next = S_EOI_CODE;
      end
      S_EOI_CODE: begin
        byte_valid = 1'b1;
        byte_out   = EOI_CODE;
        if (byte_ready) state_next = S_IDLE;
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      word_q      <= '0;
      byte_count  <= '0;
      stuff_count <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      if (state == S_WAIT && rdata_valid) word_q <= read_data;
      if (fire) byte_count <= byte_count + CNT_ONE;
      if (fire && state == S_STUFF) stuff_count <= stuff_count + CNT_ONE;
    end
  end

`ifdef JPEG_EOI_APPEND_EN
  // A request landing on the marker's final handshake is absorbed into that marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      eoi_pending <= 1'b0;
      eoi_done    <= 1'b0;
    end else begin
      eoi_done <= fire && (state == S_EOI_CODE);
      if (fire && state == S_EOI_CODE) begin
        eoi_pending <= 1'b0;
      end else if (eoi_req) begin
        eoi_pending <= 1'b1;
      end
    end
  end
`else
  logic eoi_unused;
  assign eoi_unused = eoi_req ^ (^EOI_CODE);
  assign eoi_done   = 1'b0;
`endif

endmodule

// File: tb/tb_jpeg_byte_stuffer.sv
// Self-checking bench for jpeg_byte_stuffer: vector table, hand sequences, and randomized words
// checked against a queue-based model of the stuffed byte stream.
`timescale 1ns/1ps
module tb_jpeg_byte_stuffer;
  localparam int unsigned CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             fifo_empty;
  logic [31:0]      read_data;
  logic             rdata_valid;
  logic             read_req;
  logic [7:0]       byte_out;
  logic             byte_valid;
  logic             byte_ready;
  logic             eoi_req;
  logic             eoi_done;
  logic             busy;
  logic [CNT_W-1:0] byte_count;
  logic [CNT_W-1:0] stuff_count;

  always #5 clk = ~clk;

  jpeg_byte_stuffer #(.CNT_W(CNT_W), .EOI_CODE(8'hD9)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .read_data(read_data),
    .rdata_valid(rdata_valid), .read_req(read_req), .byte_out(byte_out),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .eoi_req(eoi_req),
    .eoi_done(eoi_done), .busy(busy), .byte_count(byte_count), .stuff_count(stuff_count)
  );

  int          checks = 0;
  int          failures = 0;
  logic [31:0] fifo_q[$];
  logic [7:0]  exp_q[$];
  int unsigned exp_total, exp_stuff, eoi_pulses;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: each word yields its bytes MSB-first, every 0xFF followed by 0x00.
  task automatic model_push(input logic [31:0] w);
    logic [7:0] b;
    for (int i = 3; i >= 0; i--) begin
      b = w[8*i +: 8];
      exp_q.push_back(b);
      exp_total++;
      if (b == 8'hFF) begin
        exp_q.push_back(8'h00);
        exp_total++;
        exp_stuff++;
      end
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // FIFO peer: one-cycle read latency, shares rst with the DUT.
  always @(posedge clk) begin
    if (rst) begin
      fifo_q.delete();
      fifo_empty  <= 1'b1;
      rdata_valid <= 1'b0;
    end else if (read_req && !fifo_empty) begin
      read_data   <= fifo_q.pop_front();
      rdata_valid <= 1'b1;
      fifo_empty  <= (fifo_q.size() == 0);
    end else begin
      rdata_valid <= 1'b0;
    end
  end

  logic [7:0] held = '0;
  logic       stall_prev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", {63'd0, byte_valid}, 64'd1);
        check("stall_hold", {56'd0, byte_out}, {56'd0, held});
      end
      if (eoi_done) eoi_pulses++;
      if (read_req) check("req_only_idle", {63'd0, busy}, 64'd0);
      if (rdata_valid) check("rdata_in_wait", {63'd0, busy}, 64'd1);
      if (byte_valid && byte_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte actual=%0h required=none", byte_out);
        end else begin
          check("stream_byte", {56'd0, byte_out}, {56'd0, exp_q.pop_front()});
        end
      end
      stall_prev = byte_valid && !byte_ready;
      held       = byte_out;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    exp_total = 0;
    exp_stuff = 0;
  endtask

  // mode 0: ready held high, 1: alternating, 2: random.
  task automatic run(input int mode, input int budget, output int busy_cyc, output int req_cyc);
    bit done = 1'b0;
    busy_cyc = 0;
    req_cyc  = 0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (read_req) req_cyc++;
      if (exp_q.size() == 0 && !busy && !read_req && fifo_q.size() == 0 && !rdata_valid) begin
        done = 1'b1;
      end else begin
        @(posedge clk); #1;
        case (mode)
          0:       byte_ready = 1'b1;
          1:       byte_ready = ~byte_ready;
          default: byte_ready = 1'($urandom_range(0, 1));
        endcase
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=pending_bytes_%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  typedef struct {
    logic [31:0] word;
    logic [63:0] stream;
    int unsigned len;
    int unsigned stuff;
    int          mode;
  } vec_t;

  vec_t        vecs[8];
  logic [63:0] s;
  int          bc, rc;
  logic [31:0] w;

  initial begin
    rst = 1'b1; byte_ready = 1'b1; eoi_req = 1'b0;
    fifo_empty = 1'b1; rdata_valid = 1'b0; read_data = '0;
    eoi_pulses = 0; exp_total = 0; exp_stuff = 0;

    vecs[0] = '{32'h12345678, 64'h12345678,         4, 0, 0};
    vecs[1] = '{32'hFF00FFAB, 64'hFF0000FF00AB,     6, 2, 0};
    vecs[2] = '{32'hFFFFFFFF, 64'hFF00FF00FF00FF00, 8, 4, 0};
    vecs[3] = '{32'h000000FF, 64'h000000FF00,       5, 1, 0};
    vecs[4] = '{32'h7FFF80FE, 64'h7FFF0080FE,       5, 1, 0};
    vecs[5] = '{32'hA1B2C3D4, 64'hA1B2C3D4,         4, 0, 1};
    vecs[6] = '{32'hFF123400, 64'hFF00123400,       5, 1, 1};
    vecs[7] = '{32'h00FF00FF, 64'h00FF0000FF00,     6, 2, 2};

    do_reset();
    @(negedge clk);
    check("rst_read_req", {63'd0, read_req}, 64'd0);
    check("rst_byte_valid", {63'd0, byte_valid}, 64'd0);
    check("rst_byte_out", {56'd0, byte_out}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_eoi_done", {63'd0, eoi_done}, 64'd0);
    check("rst_byte_count", {32'd0, byte_count}, 64'd0);
    check("rst_stuff_count", {32'd0, stuff_count}, 64'd0);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_quiet", {61'd0, read_req, byte_valid, busy}, 64'd0);
    end

    for (int i = 0; i < 8; i++) begin
      do_reset();
      byte_ready = (vecs[i].mode == 1) ? 1'b0 : 1'b1;
      s = vecs[i].stream;
      for (int k = 0; k < int'(vecs[i].len); k++) exp_q.push_back(s[8*(int'(vecs[i].len)-1-k) +: 8]);
      push_word(vecs[i].word);
      run(vecs[i].mode, 200, bc, rc);
      check("vec_byte_count", {32'd0, byte_count}, 64'(vecs[i].len));
      check("vec_stuff_count", {32'd0, stuff_count}, 64'(vecs[i].stuff));
      if (vecs[i].mode == 0) begin
        check("vec_read_pulses", 64'(rc), 64'd1);
        check("vec_busy_cycles", 64'(bc), 64'(vecs[i].len + 1));
      end
    end

    // Reset after two bytes of a word: the rest must never appear.
    do_reset();
    byte_ready = 1'b1;
    exp_q.push_back(8'hDE);
    exp_q.push_back(8'hAD);
    push_word(32'hDEADBEEF);
    repeat (4) @(posedge clk);
    #1;
    check("midrst_count_before", {32'd0, byte_count}, 64'd2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_valid", {63'd0, byte_valid}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_byte_count", {32'd0, byte_count}, 64'd0);
    check("midrst_stuff_count", {32'd0, stuff_count}, 64'd0);
    check("midrst_seen_bytes", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("midrst_no_more", {62'd0, byte_valid, busy}, 64'd0);
    end

    // EOI marker behind pending data.
    do_reset();
    byte_ready = 1'b1;
    eoi_pulses = 0;
    model_push(32'h000000FF);
`ifdef JPEG_EOI_APPEND_EN
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hD9);
`endif
    push_word(32'h000000FF);
    eoi_req = 1'b1;
    @(posedge clk); #1;
    eoi_req = 1'b0;
    run(0, 200, bc, rc);
    repeat (5) @(negedge clk);
`ifdef JPEG_EOI_APPEND_EN
    check("eoi_pulses", 64'(eoi_pulses), 64'd1);
    check("eoi_byte_count", {32'd0, byte_count}, 64'd7);
`else
    check("eoi_pulses", 64'(eoi_pulses), 64'd0);
    check("eoi_byte_count", {32'd0, byte_count}, 64'd5);
`endif
    check("eoi_stuff_count", {32'd0, stuff_count}, 64'd1);

    // Repeated request while pending yields a single marker.
    eoi_pulses = 0;
    @(posedge clk); #1;
    eoi_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    eoi_req = 1'b0;
`ifdef JPEG_EOI_APPEND_EN
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hD9);
`endif
    run(0, 200, bc, rc);
    repeat (5) @(negedge clk);
`ifdef JPEG_EOI_APPEND_EN
    check("eoi2_pulses", 64'(eoi_pulses), 64'd1);
    check("eoi2_byte_count", {32'd0, byte_count}, 64'd9);
`else
    check("eoi2_pulses", 64'(eoi_pulses), 64'd0);
    check("eoi2_byte_count", {32'd0, byte_count}, 64'd5);
`endif

    // Randomized bursts of words against the reference model.
    do_reset();
    for (int it = 0; it < 30; it++) begin
      @(posedge clk); #1;
      for (int n = 0; n < int'($urandom_range(1, 3)); n++) begin
        for (int k = 0; k < 4; k++) w[8*k +: 8] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        model_push(w);
        push_word(w);
      end
      run(2, 600, bc, rc);
      check("rand_byte_count", {32'd0, byte_count}, 64'(exp_total));
      check("rand_stuff_count", {32'd0, stuff_count}, 64'(exp_stuff));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end
endmodule
